// File: rtl/rx_uart_if.sv
// Receive-side result bundle of rx_uart: received word, status pulses and busy flag.
interface rx_uart_if #(
  parameter int unsigned WL = 8
);
  logic [WL-1:0] rx_word;
  logic          rx_vld;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  modport master (output rx_word, rx_vld, frame_err, parity_err, busy);
  modport slave  (input  rx_word, rx_vld, frame_err, parity_err, busy);
endinterface

// File: rtl/rx_uart.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, LSB first, 1 stop bit.
// Define RX_PARITY_EN to expect one even-parity bit between data and stop.
module rx_uart #(
  parameter int unsigned WL        = 8,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLK_FREQ  = 100000000
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      uart_rx,
  rx_uart_if.master rx
);

  localparam int unsigned CLK_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT    = CLK_PER_BIT / 2;
  localparam int unsigned CW          = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int unsigned BW          = (WL > 1) ? $clog2(WL) : 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WL - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
`ifdef RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state, state_nx;
  logic            sync_q1, rx_s;
  logic [CW-1:0]   baud_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [WL-1:0]   shreg;
  logic [WL-1:0]   word_q;
  logic            vld_q, ferr_q;

  logic            cnt_clr;
  logic            shift_en;
  logic            load_word;
  logic            ferr_set;
  logic            tick_half, tick_bit;

`ifdef RX_PARITY_EN
  logic            par_bit;
  logic            par_load;
  logic            perr_set;
  logic            perr_q;
  logic            par_bad;
  assign par_bad = (^shreg) ^ par_bit;
`endif

  assign tick_half = (baud_cnt == HALF_END);
  assign tick_bit  = (baud_cnt == BIT_END);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_q1 <= uart_rx;
      rx_s    <= sync_q1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b1;
    shift_en  = 1'b0;
    load_word = 1'b0;
    ferr_set  = 1'b0;
`ifdef RX_PARITY_EN
    par_load  = 1'b0;
    perr_set  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) state_nx = START;
      end
      START: begin
        cnt_clr = tick_half;
        // a line that is already high again at mid start bit was a glitch
        if (tick_half) state_nx = rx_s ? IDLE : DATA;
      end
      DATA: begin
        cnt_clr = tick_bit;
        if (tick_bit) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        cnt_clr = tick_bit;
        if (tick_bit) begin
          par_load = 1'b1;
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        cnt_clr = tick_bit;
        if (tick_bit) begin
          if (!rx_s) begin
            ferr_set = 1'b1;
            state_nx = BREAK;
          end else begin
            state_nx = IDLE;
`ifdef RX_PARITY_EN
            if (par_bad) perr_set  = 1'b1;
            else         load_word = 1'b1;
`else
            load_word = 1'b1;
`endif
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      baud_cnt <= cnt_clr ? '0 : baud_cnt + 1'b1;
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
      // LSB arrives first, so shift right and insert at the top
      if (shift_en) shreg <= {rx_s, shreg[WL-1:1]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_q <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (load_word) word_q <= shreg;
      vld_q  <= load_word;
      ferr_q <= ferr_set;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (par_load) par_bit <= rx_s;
      perr_q <= perr_set;
    end
  end
  assign rx.parity_err = perr_q;
`else
  assign rx.parity_err = 1'b0;
`endif

  assign rx.rx_word   = word_q;
  assign rx.rx_vld    = vld_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state != IDLE);

endmodule

// File: tb/tb_rx_uart.sv
// Randomized bench for rx_uart against a frame-level reference model.
module tb_rx_uart;
  localparam int unsigned WL  = 8;
  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;

  always #5 clk = ~clk;

  rx_uart_if #(.WL(WL)) rx ();

  rx_uart #(.WL(WL), .BAUD_RATE(62500), .CLK_FREQ(1000000)) dut (
    .CLK(clk), .RST(rst), .uart_rx(uart_rx), .rx(rx)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // observed side
  int cyc = 0;
  int vld_cnt = 0, ferr_cnt = 0, perr_cnt = 0, overlap = 0, wide = 0;
  logic [WL-1:0] got_q[$];
  int vld_cyc_q[$];
  logic prev_vld = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx.rx_vld) begin
        vld_cnt++;
        got_q.push_back(rx.rx_word);
        vld_cyc_q.push_back(cyc);
      end
      if (rx.frame_err)  ferr_cnt++;
      if (rx.parity_err) perr_cnt++;
      if (rx.rx_vld && rx.frame_err) overlap++;
      if ((rx.rx_vld && prev_vld) || (rx.frame_err && prev_ferr) || (rx.parity_err && prev_perr))
        wide++;
    end
    prev_vld  = rx.rx_vld;
    prev_ferr = rx.frame_err;
    prev_perr = rx.parity_err;
  end

  // reference model: whole-frame outcome
  logic [WL-1:0] exp_q[$];
  int exp_vld = 0, exp_ferr = 0, exp_perr = 0;
  logic [WL-1:0] model_word = '0;

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [WL-1:0] d, input logic stop_b, input logic flip);
    drive_bit(1'b0);
    for (int i = 0; i < WL; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
    drive_bit((^d) ^ flip);
`endif
    drive_bit(stop_b);
    if (!stop_b) exp_ferr++;
`ifdef RX_PARITY_EN
    else if (flip) exp_perr++;
`endif
    else begin
      exp_q.push_back(d);
      model_word = d;
      exp_vld++;
    end
  endtask

  task automatic settle(input string tag);
    int n = 0;
    int m;
    while ((vld_cnt != exp_vld || ferr_cnt != exp_ferr || perr_cnt != exp_perr) && n < 4*CPB) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, ".vld_cnt"},  vld_cnt,  exp_vld);
    check({tag, ".ferr_cnt"}, ferr_cnt, exp_ferr);
    check({tag, ".perr_cnt"}, perr_cnt, exp_perr);
    check({tag, ".rx_word"},  rx.rx_word, model_word);
    check({tag, ".nwords"},   got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({tag, ".word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [WL-1:0] loop_w [5] = '{8'h43, 8'h45, 8'h52, 8'h50, 8'h41};

  initial begin
    int t0, lat, glen;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rx_word",    rx.rx_word, 0);
    check("rst.rx_vld",     rx.rx_vld, 0);
    check("rst.frame_err",  rx.frame_err, 0);
    check("rst.parity_err", rx.parity_err, 0);
    check("rst.busy",       rx.busy, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle.busy", rx.busy, 0);

    // back-to-back loopback words, first one also timed
    t0 = cyc;
    for (int i = 0; i < 5; i++) send_frame(loop_w[i], 1'b1, 1'b0);
    if (vld_cyc_q.size() > 0) lat = vld_cyc_q[0] - t0;
    else                      lat = -1;
    check("latency_in_154_156", (lat >= 154 && lat <= 156), 1);
    settle("loop");

    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3*CPB)) @(posedge clk);
      #1;
      send_frame(WL'($urandom), 1'b1, 1'b0);
    end
    settle("rand");

    // short low pulses must be rejected at mid start bit
    for (int k = 0; k < 3; k++) begin
      glen = $urandom_range(1, 5);
      uart_rx = 1'b0;
      repeat (glen) @(posedge clk);
      #1;
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
      check("glitch.busy_hi", rx.busy, 1);
      repeat (CPB) @(posedge clk);
      #1;
      check("glitch.busy_lo", rx.busy, 0);
    end
    settle("glitch");

    // stop bit low, then line held low: exactly one frame error
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (30*CPB) @(posedge clk);
    #1;
    check("break.busy", rx.busy, 1);
    uart_rx = 1'b1;
    repeat (2*CPB) @(posedge clk);
    #1;
    settle("break");
    send_frame(8'hA5, 1'b1, 1'b0);
    settle("after_break");

    // reset in the middle of data bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (CPB/2) @(posedge clk);
    #3;
    check("midframe.busy", rx.busy, 1);
    rst = 1'b1;
    #1;
    model_word = '0;
    check("arst.rx_word",    rx.rx_word, 0);
    check("arst.rx_vld",     rx.rx_vld, 0);
    check("arst.frame_err",  rx.frame_err, 0);
    check("arst.parity_err", rx.parity_err, 0);
    check("arst.busy",       rx.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2*CPB) @(posedge clk);
    #1;
    settle("post_rst");
    send_frame(8'h3C, 1'b1, 1'b0);
    settle("after_rst");

`ifdef RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    settle("par_bad");
    send_frame(8'h07, 1'b1, 1'b0);
    settle("par_good");
`endif

    check("no_vld_ferr_overlap", overlap, 0);
    check("pulse_width_one", wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
